// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
//
// Direct-mapped instruction cache (16-byte lines, 4 words) with an integrated
// request/grant/4-beat line refill controller.
//
// Hits are answered combinationally in IDLE. A miss latches the line address,
// requests memory, collects four beats into a staging register and installs
// the line into the latched set.
//
// Build option: define ICACHE_MISS_CNT_EN to build a saturating miss counter
// on Cache_MissCnt. Without it the port is tied to zero.
//
// Ports
//   Clk, Resetb           clock, asynchronous active-low reset
//   Ifetch_WpPcIn[31:0]   line address from fetch queue (bits [3:0] ignored)
//   Ifetch_ReadCache      fetch queue line read request
//   IFQ_Flush             fetch queue flush, suppresses hit and miss handling
//   Cache_ReadHit         requested line present and delivered this cycle
//   Cache_Cd0..3[31:0]    words 0..3 of the indexed line
//   Mem_Req               refill request, held until Mem_Gnt
//   Mem_Addr[31:0]        refill line address {tag, index, 4'b0000}
//   Mem_Gnt               memory accepts the request
//   Mem_Valid, Mem_Data   one refill word per valid cycle, word0..word3
//   Cache_MissCnt[15:0]   miss counter (zero unless ICACHE_MISS_CNT_EN)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | lookup active, hits reported, misses start a refill
// REQ   | Mem_Req asserted with stable Mem_Addr, waiting for Mem_Gnt
// FILL  | collecting four Mem_Valid beats, install on the fourth

module icache_refill_ctrl #(
    parameter int SETS = 16
) (
    input  logic        Clk,
    input  logic        Resetb,
    input  logic [31:0] Ifetch_WpPcIn,
    input  logic        Ifetch_ReadCache,
    input  logic        IFQ_Flush,
    output logic        Cache_ReadHit,
    output logic [31:0] Cache_Cd0,
    output logic [31:0] Cache_Cd1,
    output logic [31:0] Cache_Cd2,
    output logic [31:0] Cache_Cd3,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Gnt,
    input  logic        Mem_Valid,
    input  logic [31:0] Mem_Data,
    output logic [15:0] Cache_MissCnt
);

    localparam int IW = $clog2(SETS);
    localparam int TW = 28 - IW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0]  idx;
    logic [TW-1:0]  tag_in;
    logic [SETS-1:0] valid;
    logic [TW-1:0]  tag_mem  [SETS];
    logic [127:0]   data_mem [SETS];

    logic [31:0]    mem_addr_q;
    logic [IW-1:0]  fill_idx;
    logic [TW-1:0]  fill_tag;
    logic [1:0]     beat;
    logic [127:0]   stage;

    logic           lookup_hit;
    logic           start_miss;
    logic           fill_done;

    // The byte offset within a line never affects selection.
    logic           unused_pc_bits;
    assign unused_pc_bits = ^Ifetch_WpPcIn[3:0];

    assign idx      = Ifetch_WpPcIn[4+IW-1:4];
    assign tag_in   = Ifetch_WpPcIn[31:4+IW];
    assign fill_idx = mem_addr_q[4+IW-1:4];
    assign fill_tag = mem_addr_q[31:4+IW];

    assign lookup_hit = valid[idx] && (tag_mem[idx] == tag_in);

    assign Cache_Cd0 = data_mem[idx][31:0];
    assign Cache_Cd1 = data_mem[idx][63:32];
    assign Cache_Cd2 = data_mem[idx][95:64];
    assign Cache_Cd3 = data_mem[idx][127:96];
    assign Mem_Addr  = mem_addr_q;

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        Cache_ReadHit = 1'b0;
        Mem_Req       = 1'b0;
        start_miss    = 1'b0;
        fill_done     = 1'b0;
        case (state)
            IDLE: begin
                if (Ifetch_ReadCache && !IFQ_Flush) begin
                    if (lookup_hit) begin
                        Cache_ReadHit = 1'b1;
                    end else begin
                        start_miss = 1'b1;
                        state_nxt  = REQ;
                    end
                end
            end
            REQ: begin
                Mem_Req = 1'b1;
                if (Mem_Gnt) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (Mem_Valid && (beat == 2'd3)) begin
                    fill_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            mem_addr_q <= 32'h0;
            beat       <= 2'd0;
            stage      <= 128'h0;
            valid      <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_mem[i]  <= '0;
                data_mem[i] <= 128'h0;
            end
        end else begin
            if (start_miss) begin
                mem_addr_q <= {Ifetch_WpPcIn[31:4], 4'b0000};
            end
            if ((state == REQ) && Mem_Gnt) begin
                beat <= 2'd0;
            end
            if ((state == FILL) && Mem_Valid) begin
                beat                 <= beat + 2'd1;
                stage[32*beat +: 32] <= Mem_Data;
            end
            // The fourth word goes straight from the bus into the line.
            if (fill_done) begin
                valid[fill_idx]    <= 1'b1;
                tag_mem[fill_idx]  <= fill_tag;
                data_mem[fill_idx] <= {Mem_Data, stage[95:0]};
            end
        end
    end

`ifdef ICACHE_MISS_CNT_EN
    logic [15:0] miss_cnt;

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            miss_cnt <= 16'h0;
        end else if (start_miss && (miss_cnt != 16'hFFFF)) begin
            miss_cnt <= miss_cnt + 16'd1;
        end
    end

    assign Cache_MissCnt = miss_cnt;
`else
    assign Cache_MissCnt = 16'h0000;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;

    logic        Clk = 1'b0;
    logic        Resetb;
    logic [31:0] Ifetch_WpPcIn;
    logic        Ifetch_ReadCache;
    logic        IFQ_Flush;
    logic        Cache_ReadHit;
    logic [31:0] Cache_Cd0, Cache_Cd1, Cache_Cd2, Cache_Cd3;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Gnt;
    logic        Mem_Valid;
    logic [31:0] Mem_Data;
    logic [15:0] Cache_MissCnt;

    icache_refill_ctrl #(.SETS(16)) dut (
        .Clk              (Clk),
        .Resetb           (Resetb),
        .Ifetch_WpPcIn    (Ifetch_WpPcIn),
        .Ifetch_ReadCache (Ifetch_ReadCache),
        .IFQ_Flush        (IFQ_Flush),
        .Cache_ReadHit    (Cache_ReadHit),
        .Cache_Cd0        (Cache_Cd0),
        .Cache_Cd1        (Cache_Cd1),
        .Cache_Cd2        (Cache_Cd2),
        .Cache_Cd3        (Cache_Cd3),
        .Mem_Req          (Mem_Req),
        .Mem_Addr         (Mem_Addr),
        .Mem_Gnt          (Mem_Gnt),
        .Mem_Valid        (Mem_Valid),
        .Mem_Data         (Mem_Data),
        .Cache_MissCnt    (Cache_MissCnt)
    );

    always #5 Clk = ~Clk;

`ifdef ICACHE_MISS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [127:0] L1 = {32'h44, 32'h33, 32'h22, 32'h11};
    localparam logic [127:0] L2 = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    localparam logic [127:0] L3 = {32'h54, 32'h53, 32'h52, 32'h51};
    localparam logic [127:0] L4 = {32'h64, 32'h63, 32'h62, 32'h61};
    localparam logic [127:0] L5 = {32'h84, 32'h83, 32'h82, 32'h81};

    typedef struct packed {
        logic         rd;
        logic         fl;
        logic [31:0]  pc;
        logic         gnt;
        logic         mv;
        logic [31:0]  md;
        logic         hit;
        logic         req;
        logic [31:0]  addr;
        logic [127:0] cd;
        logic [15:0]  misses;
    } vec_t;

    vec_t vq[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic rd, input logic fl, input logic [31:0] pc,
                                input logic gnt, input logic mv, input logic [31:0] md,
                                input logic hit, input logic req, input logic [31:0] addr,
                                input logic [127:0] cd, input int misses);
        vec_t v;
        v.rd = rd; v.fl = fl; v.pc = pc; v.gnt = gnt; v.mv = mv; v.md = md;
        v.hit = hit; v.req = req; v.addr = addr; v.cd = cd;
        v.misses = CNT_EN ? 16'(misses) : 16'h0;
        return v;
    endfunction

    task automatic add(input vec_t v);
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive_vec(input vec_t v);
        Ifetch_ReadCache = v.rd;
        IFQ_Flush        = v.fl;
        Ifetch_WpPcIn    = v.pc;
        Mem_Gnt          = v.gnt;
        Mem_Valid        = v.mv;
        Mem_Data         = v.md;
    endtask

    task automatic check_vec(input vec_t v, input string nm);
        chk({nm, ".hit"},  128'(Cache_ReadHit), 128'(v.hit));
        chk({nm, ".req"},  128'(Mem_Req),       128'(v.req));
        chk({nm, ".addr"}, 128'(Mem_Addr),      128'(v.addr));
        chk({nm, ".cd"},   {Cache_Cd3, Cache_Cd2, Cache_Cd1, Cache_Cd0}, v.cd);
        chk({nm, ".cnt"},  128'(Cache_MissCnt), 128'(v.misses));
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        drive_vec(v);
        @(negedge Clk);
        check_vec(v, nm);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Resetb = 1'b0;
        drive_vec(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 128'h0, 0));

        // Cold miss, zero-wait memory; stray Gnt/Valid in IDLE
        add(mk(0, 0, 32'h040, 1, 1, 32'h99, 0, 0, 32'h0,   128'h0, 0));
        add(mk(1, 0, 32'h040, 0, 0, 32'h0,  0, 0, 32'h0,   128'h0, 0));
        add(mk(0, 0, 32'h040, 1, 0, 32'h0,  0, 1, 32'h040, 128'h0, 1));
        add(mk(0, 0, 32'h040, 0, 1, 32'h11, 0, 0, 32'h040, 128'h0, 1));
        add(mk(0, 0, 32'h040, 0, 1, 32'h22, 0, 0, 32'h040, 128'h0, 1));
        add(mk(0, 0, 32'h040, 0, 1, 32'h33, 0, 0, 32'h040, 128'h0, 1));
        add(mk(0, 0, 32'h040, 0, 1, 32'h44, 0, 0, 32'h040, 128'h0, 1));
        add(mk(1, 0, 32'h044, 0, 0, 32'h0,  1, 0, 32'h040, L1,     1));
        // Flush suppression on a resident line
        add(mk(1, 1, 32'h040, 0, 0, 32'h0,  0, 0, 32'h040, L1,     1));
        add(mk(0, 0, 32'h040, 1, 1, 32'h77, 0, 0, 32'h040, L1,     1));
        // Conflict on index 4
        add(mk(1, 0, 32'h140, 0, 0, 32'h0,  0, 0, 32'h040, L1,     1));
        add(mk(0, 0, 32'h140, 1, 0, 32'h0,  0, 1, 32'h140, L1,     2));
        add(mk(0, 0, 32'h140, 0, 1, 32'hA1, 0, 0, 32'h140, L1,     2));
        add(mk(0, 0, 32'h140, 0, 1, 32'hA2, 0, 0, 32'h140, L1,     2));
        add(mk(0, 0, 32'h140, 0, 1, 32'hA3, 0, 0, 32'h140, L1,     2));
        add(mk(0, 0, 32'h140, 0, 1, 32'hA4, 0, 0, 32'h140, L1,     2));
        add(mk(1, 0, 32'h140, 0, 0, 32'h0,  1, 0, 32'h140, L2,     2));
        add(mk(1, 0, 32'h040, 0, 0, 32'h0,  0, 0, 32'h140, L2,     2));
        // Stalled grant with stray Mem_Valid in REQ, then gapped beats
        add(mk(0, 0, 32'h040, 0, 1, 32'hDEAD, 0, 1, 32'h040, L2,   3));
        add(mk(0, 0, 32'h040, 0, 0, 32'h0,    0, 1, 32'h040, L2,   3));
        add(mk(0, 0, 32'h040, 0, 1, 32'hBEEF, 0, 1, 32'h040, L2,   3));
        add(mk(0, 0, 32'h040, 0, 0, 32'h0,    0, 1, 32'h040, L2,   3));
        add(mk(0, 0, 32'h040, 0, 0, 32'h0,    0, 1, 32'h040, L2,   3));
        add(mk(0, 0, 32'h040, 1, 1, 32'hBAD,  0, 1, 32'h040, L2,   3));
        add(mk(0, 0, 32'h040, 0, 1, 32'h51, 0, 0, 32'h040, L2,     3));
        add(mk(0, 0, 32'h040, 0, 0, 32'h0,  0, 0, 32'h040, L2,     3));
        add(mk(0, 0, 32'h040, 0, 1, 32'h52, 0, 0, 32'h040, L2,     3));
        add(mk(0, 0, 32'h040, 0, 0, 32'h0,  0, 0, 32'h040, L2,     3));
        add(mk(0, 0, 32'h040, 0, 0, 32'h0,  0, 0, 32'h040, L2,     3));
        add(mk(0, 0, 32'h040, 0, 1, 32'h53, 0, 0, 32'h040, L2,     3));
        add(mk(0, 0, 32'h040, 0, 1, 32'h54, 0, 0, 32'h040, L2,     3));
        add(mk(1, 0, 32'h040, 0, 0, 32'h0,  1, 0, 32'h040, L3,     3));
        // Flushed request to an empty set starts nothing
        add(mk(1, 1, 32'h050, 0, 0, 32'h0,  0, 0, 32'h040, 128'h0, 3));
        add(mk(0, 0, 32'h050, 0, 0, 32'h0,  0, 0, 32'h040, 128'h0, 3));

        repeat (2) @(posedge Clk);
        #1;
        Resetb = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            run_vec(vq[i], $sformatf("vec[%0d]", i));
        end

        // Flush arriving mid-FILL after two beats
        run_vec(mk(1, 0, 32'h080, 0, 0, 32'h0,  0, 0, 32'h040, 128'h0, 3), "mflush.miss");
        run_vec(mk(0, 0, 32'h080, 1, 0, 32'h0,  0, 1, 32'h080, 128'h0, 4), "mflush.req");
        run_vec(mk(0, 0, 32'h080, 0, 1, 32'h61, 0, 0, 32'h080, 128'h0, 4), "mflush.b0");
        run_vec(mk(0, 0, 32'h080, 0, 1, 32'h62, 0, 0, 32'h080, 128'h0, 4), "mflush.b1");
        run_vec(mk(1, 1, 32'h040, 0, 1, 32'h63, 0, 0, 32'h080, L3,     4), "mflush.b2");
        run_vec(mk(1, 0, 32'h040, 0, 1, 32'h64, 0, 0, 32'h080, L3,     4), "mflush.b3");
        run_vec(mk(1, 0, 32'h080, 0, 0, 32'h0,  1, 0, 32'h080, L4,     4), "mflush.hit");
        run_vec(mk(1, 0, 32'h040, 0, 0, 32'h0,  1, 0, 32'h080, L3,     4), "mflush.old");

        // Reset pulsed after the first refill beat
        run_vec(mk(1, 0, 32'h0C0, 0, 0, 32'h0,  0, 0, 32'h080, 128'h0, 4), "rst.miss");
        run_vec(mk(0, 0, 32'h0C0, 1, 0, 32'h0,  0, 1, 32'h0C0, 128'h0, 5), "rst.req");
        run_vec(mk(0, 0, 32'h0C0, 0, 1, 32'h71, 0, 0, 32'h0C0, 128'h0, 5), "rst.b0");
        begin
            vec_t v;
            v = mk(0, 0, 32'h040, 0, 0, 32'h0, 0, 0, 32'h0, 128'h0, 0);
            drive_vec(v);
            #1 Resetb = 1'b0;
            #1 Resetb = 1'b1;
            @(negedge Clk);
            check_vec(v, "rst.after");
            @(posedge Clk);
            #1;
        end
        run_vec(mk(0, 0, 32'h0C0, 0, 1, 32'h72, 0, 0, 32'h0,   128'h0, 0), "rst.late0");
        run_vec(mk(0, 0, 32'h0C0, 0, 1, 32'h73, 0, 0, 32'h0,   128'h0, 0), "rst.late1");
        run_vec(mk(1, 0, 32'h040, 0, 0, 32'h0,  0, 0, 32'h0,   128'h0, 0), "rst.remiss");
        run_vec(mk(0, 0, 32'h040, 1, 0, 32'h0,  0, 1, 32'h040, 128'h0, 1), "rst.req2");
        run_vec(mk(0, 0, 32'h040, 0, 1, 32'h81, 0, 0, 32'h040, 128'h0, 1), "rst.f0");
        run_vec(mk(0, 0, 32'h040, 0, 1, 32'h82, 0, 0, 32'h040, 128'h0, 1), "rst.f1");
        run_vec(mk(0, 0, 32'h040, 0, 1, 32'h83, 0, 0, 32'h040, 128'h0, 1), "rst.f2");
        run_vec(mk(0, 0, 32'h040, 0, 1, 32'h84, 0, 0, 32'h040, 128'h0, 1), "rst.f3");
        run_vec(mk(1, 0, 32'h040, 0, 0, 32'h0,  1, 0, 32'h040, L5,     1), "rst.hit");
        run_vec(mk(1, 0, 32'h0C0, 0, 0, 32'h0,  0, 0, 32'h040, 128'h0, 1), "rst.c0inv");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
